// File: rtl/ddr2_arbiter.sv
// Two-port DDR2 command arbiter between the instruction and data caches.
// Per-port command FIFOs, round-robin grant, read data routed to the requester.
module ddr2_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              c0_enable,
    input  logic              c0_read,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_available,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_overflow,
    input  logic              c1_enable,
    input  logic              c1_read,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_available,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_overflow,
    output logic              mem_enable,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_available,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_grant;

    logic              in_en    [2];
    logic              in_read  [2];
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_wdata [2];

    assign in_en[0]    = c0_enable;
    assign in_en[1]    = c1_enable;
    assign in_read[0]  = c0_read;
    assign in_read[1]  = c1_read;
    assign in_addr[0]  = c0_addr;
    assign in_addr[1]  = c1_addr;
    assign in_wdata[0] = c0_wdata;
    assign in_wdata[1] = c1_wdata;

    logic              q_read  [2][QDEPTH];
    logic [ADDR_W-1:0] q_addr  [2][QDEPTH];
    logic [DATA_W-1:0] q_wdata [2][QDEPTH];

    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [CW-1:0] count  [2];
    logic          ovf    [2];

    logic empty   [2];
    logic full    [2];
    logic pop     [2];
    logic push_ok [2];

    logic grant_valid;
    logic gp;

    assign c0_overflow = ovf[0];
    assign c1_overflow = ovf[1];

    // FIFO status; a pop frees the slot a same-cycle push lands in
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            empty[p]   = (count[p] == '0);
            full[p]    = (count[p] == FULL_CNT);
            pop[p]     = (state == ISSUE) && mem_ready && (owner == 1'(p));
            push_ok[p] = in_en[p] && (!full[p] || pop[p]);
        end
    end

    // Round-robin choice; on a tie the port not granted last time wins
    always_comb begin
        grant_valid = !empty[0] || !empty[1];
        if (!empty[0] && !empty[1]) begin
            gp = ~last_grant;
        end else begin
            gp = empty[0];
        end
    end

    // FIFO storage, written at the tail on every accepted push
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_ok[p]) begin
                q_read[p][wr_ptr[p]]  <= in_read[p];
                q_addr[p][wr_ptr[p]]  <= in_addr[p];
                q_wdata[p][wr_ptr[p]] <= in_wdata[p];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
                ovf[p]    <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push_ok[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PW'(1);
                end
                if (in_en[p] && !push_ok[p]) begin
                    ovf[p] <= 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PW'(1);
                end
                if (push_ok[p] && !pop[p]) begin
                    count[p] <= count[p] + CW'(1);
                end else if (!push_ok[p] && pop[p]) begin
                    count[p] <= count[p] - CW'(1);
                end
            end
        end
    end

    // Arbiter FSM with registered memory command and read-return outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            mem_enable   <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            c0_available <= 1'b0;
            c1_available <= 1'b0;
            c0_rdata     <= '0;
            c1_rdata     <= '0;
        end else begin
            c0_available <= 1'b0;
            c1_available <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= gp;
                        last_grant <= gp;
                        mem_enable <= 1'b1;
                        mem_read   <= q_read[gp][rd_ptr[gp]];
                        mem_addr   <= q_addr[gp][rd_ptr[gp]];
                        mem_wdata  <= q_wdata[gp][rd_ptr[gp]];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_enable <= 1'b0;
                        state      <= mem_read ? WAIT_RD : IDLE;
                    end
                end
                WAIT_RD: begin
                    if (mem_available) begin
                        if (owner) begin
                            c1_rdata     <= mem_data;
                            c1_available <= 1'b1;
                        end else begin
                            c0_rdata     <= mem_data;
                            c0_available <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Directed bench for ddr2_arbiter: vector table plus corner-case sequences.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_ddr2_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rstn;
    logic          c0_enable, c0_read, c0_available, c0_overflow;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_wdata, c0_rdata;
    logic          c1_enable, c1_read, c1_available, c1_overflow;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_wdata, c1_rdata;
    logic          mem_enable, mem_read, mem_ready, mem_available;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .c0_enable(c0_enable), .c0_read(c0_read), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_available(c0_available),
        .c0_rdata(c0_rdata), .c0_overflow(c0_overflow),
        .c1_enable(c1_enable), .c1_read(c1_read), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_available(c1_available),
        .c1_rdata(c1_rdata), .c1_overflow(c1_overflow),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_available(mem_available), .mem_data(mem_data)
    );

    typedef struct {
        logic          rstn;
        logic          c0e;
        logic          c0r;
        logic [AW-1:0] c0a;
        logic          c1e;
        logic          c1r;
        logic [AW-1:0] c1a;
        logic [31:0]   wp;
        logic          rdy;
        logic          av;
        logic [7:0]    dp;
        logic          e_en;
        logic          chk;
        logic          e_rd;
        logic [AW-1:0] e_a;
        logic [31:0]   e_wp;
        logic          e_av0;
        logic          e_av1;
        logic          chkr;
        logic [7:0]    r0;
        logic [7:0]    r1;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DW-1:0] rep32(input logic [31:0] p);
        return {4{p}};
    endfunction

    function automatic logic [DW-1:0] rep8(input logic [7:0] p);
        return {16{p}};
    endfunction

    function automatic vec_t mk(
        input logic rs, input logic c0e, input logic c0r,
        input logic [AW-1:0] c0a, input logic c1e, input logic c1r,
        input logic [AW-1:0] c1a, input logic [31:0] wp,
        input logic rdy, input logic av, input logic [7:0] dp,
        input logic e_en, input logic chk, input logic e_rd,
        input logic [AW-1:0] e_a, input logic [31:0] e_wp,
        input logic e_av0, input logic e_av1, input logic chkr,
        input logic [7:0] r0, input logic [7:0] r1);
        vec_t v;
        v.rstn = rs;   v.c0e = c0e;   v.c0r = c0r;   v.c0a = c0a;
        v.c1e = c1e;   v.c1r = c1r;   v.c1a = c1a;   v.wp = wp;
        v.rdy = rdy;   v.av = av;     v.dp = dp;
        v.e_en = e_en; v.chk = chk;   v.e_rd = e_rd; v.e_a = e_a;
        v.e_wp = e_wp; v.e_av0 = e_av0; v.e_av1 = e_av1;
        v.chkr = chkr; v.r0 = r0;     v.r1 = r1;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_enable = 1'b0; c0_read = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_enable = 1'b0; c1_read = 1'b0; c1_addr = '0; c1_wdata = '0;
        mem_available = 1'b0; mem_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_enable"}, DW'(mem_enable), '0);
        check({tag, " mem_read"}, DW'(mem_read), '0);
        check({tag, " mem_addr"}, DW'(mem_addr), '0);
        check({tag, " mem_wdata"}, mem_wdata, '0);
        check({tag, " c0_available"}, DW'(c0_available), '0);
        check({tag, " c1_available"}, DW'(c1_available), '0);
        check({tag, " c0_rdata"}, c0_rdata, '0);
        check({tag, " c1_rdata"}, c1_rdata, '0);
        check({tag, " c0_overflow"}, DW'(c0_overflow), '0);
        check({tag, " c1_overflow"}, DW'(c1_overflow), '0);
    endtask

    initial begin
        rstn = 1'b0;
        mem_ready = 1'b0;
        idle_inputs();

        // rs c0e c0r c0a c1e c1r c1a wp rdy av dp | en chk rd a wp av0 av1 chkr r0 r1
        // reset, then single port-0 read with data returned 5 edges later
        tbl.push_back(mk(0,0,0,27'h0,0,0,27'h0,0,0,0,8'h00, 0,1,0,27'h0,0,0,0,1,8'h00,8'h00));
        tbl.push_back(mk(1,1,1,27'h0000120,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 1,1,1,27'h0000120,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'hA5, 0,0,0,27'h0,0,1,0,1,8'hA5,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,1,8'hA5,8'h00));
        // reset clears rdata; both ports read together, then alternate
        tbl.push_back(mk(0,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,1,0,27'h0,0,0,0,1,8'h00,8'h00));
        tbl.push_back(mk(1,1,1,27'h0000200,1,1,27'h0000300,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,1,1,27'h0000240,1,1,27'h0000340,0,1,0,8'h00, 1,1,1,27'h0000200,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'h11, 0,0,0,27'h0,0,1,0,1,8'h11,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 1,1,1,27'h0000300,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'h22, 0,0,0,27'h0,0,0,1,1,8'h11,8'h22));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 1,1,1,27'h0000240,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'h33, 0,0,0,27'h0,0,1,0,1,8'h33,8'h22));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 1,1,1,27'h0000340,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'h44, 0,0,0,27'h0,0,0,1,1,8'h33,8'h44));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,1,8'h33,8'h44));
        // port-1 write-back then refill: write reaches memory first
        tbl.push_back(mk(1,0,0,27'h0,1,0,27'h0004010,32'hDEADBEEF,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,1,1,27'h0008010,0,1,0,8'h00, 1,1,0,27'h0004010,32'hDEADBEEF,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 1,1,1,27'h0008010,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,0,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,1,8'h55, 0,0,0,27'h0,0,0,1,1,8'h33,8'h55));
        tbl.push_back(mk(1,0,0,27'h0,0,0,27'h0,0,1,0,8'h00, 0,0,0,27'h0,0,0,0,1,8'h33,8'h55));

        #1;
        foreach (tbl[i]) begin
            rstn          = tbl[i].rstn;
            c0_enable     = tbl[i].c0e;
            c0_read       = tbl[i].c0r;
            c0_addr       = tbl[i].c0a;
            c0_wdata      = rep32(tbl[i].wp);
            c1_enable     = tbl[i].c1e;
            c1_read       = tbl[i].c1r;
            c1_addr       = tbl[i].c1a;
            c1_wdata      = rep32(tbl[i].wp);
            mem_ready     = tbl[i].rdy;
            mem_available = tbl[i].av;
            mem_data      = rep8(tbl[i].dp);
            tick();
            check($sformatf("v%0d mem_enable", i), DW'(mem_enable), DW'(tbl[i].e_en));
            check($sformatf("v%0d c0_available", i), DW'(c0_available), DW'(tbl[i].e_av0));
            check($sformatf("v%0d c1_available", i), DW'(c1_available), DW'(tbl[i].e_av1));
            check($sformatf("v%0d c0_overflow", i), DW'(c0_overflow), '0);
            check($sformatf("v%0d c1_overflow", i), DW'(c1_overflow), '0);
            if (tbl[i].chk) begin
                check($sformatf("v%0d mem_read", i), DW'(mem_read), DW'(tbl[i].e_rd));
                check($sformatf("v%0d mem_addr", i), DW'(mem_addr), DW'(tbl[i].e_a));
                check($sformatf("v%0d mem_wdata", i), mem_wdata, rep32(tbl[i].e_wp));
            end
            if (tbl[i].chkr) begin
                check($sformatf("v%0d c0_rdata", i), c0_rdata, rep8(tbl[i].r0));
                check($sformatf("v%0d c1_rdata", i), c1_rdata, rep8(tbl[i].r1));
            end
        end
        idle_inputs();

        // overflow on third push, stall with mem_ready low, in-order drain
        rstn = 1'b0; mem_ready = 1'b0;
        tick();
        rstn = 1'b1;
        c0_enable = 1'b1; c0_read = 1'b0;
        c0_addr = 27'h0000A10; c0_wdata = rep32(32'h1111_0001);
        tick();
        c0_addr = 27'h0000A20; c0_wdata = rep32(32'h2222_0002);
        tick();
        check("ovf two pushes", DW'(c0_overflow), '0);
        check("ovf grant en", DW'(mem_enable), DW'(1'b1));
        c0_addr = 27'h0000A30; c0_wdata = rep32(32'h3333_0003);
        tick();
        c0_enable = 1'b0;
        check("ovf set", DW'(c0_overflow), DW'(1'b1));
        check("ovf other port", DW'(c1_overflow), '0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall enable", DW'(mem_enable), DW'(1'b1));
            check("stall addr", DW'(mem_addr), DW'(27'h0000A10));
            check("stall read", DW'(mem_read), '0);
            check("stall wdata", mem_wdata, rep32(32'h1111_0001));
        end
        mem_ready = 1'b1;
        tick();
        check("first ready accept", DW'(mem_enable), '0);
        tick();
        check("second enable", DW'(mem_enable), DW'(1'b1));
        check("second addr", DW'(mem_addr), DW'(27'h0000A20));
        check("second wdata", mem_wdata, rep32(32'h2222_0002));
        tick();
        check("second accept", DW'(mem_enable), '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dropped never issued", DW'(mem_enable), '0);
            check("ovf sticky", DW'(c0_overflow), DW'(1'b1));
        end

        // push and pop in the same cycle on a full FIFO is not a drop
        rstn = 1'b0; mem_ready = 1'b0;
        tick();
        rstn = 1'b1;
        check("ovf cleared by reset", DW'(c0_overflow), '0);
        c0_enable = 1'b1; c0_read = 1'b0;
        c0_addr = 27'h0000B10; c0_wdata = rep32(32'hB100_0001);
        tick();
        c0_addr = 27'h0000B20; c0_wdata = rep32(32'hB200_0002);
        tick();
        c0_addr = 27'h0000B30; c0_wdata = rep32(32'hB300_0003);
        mem_ready = 1'b1;
        tick();
        c0_enable = 1'b0;
        check("full push+pop ovf", DW'(c0_overflow), '0);
        check("full push+pop accept", DW'(mem_enable), '0);
        tick();
        check("fp B2 addr", DW'(mem_addr), DW'(27'h0000B20));
        tick();
        tick();
        check("fp B3 enable", DW'(mem_enable), DW'(1'b1));
        check("fp B3 addr", DW'(mem_addr), DW'(27'h0000B30));
        check("fp B3 wdata", mem_wdata, rep32(32'hB300_0003));
        tick();
        check("fp B3 accept", DW'(mem_enable), '0);
        check("fp ovf still 0", DW'(c0_overflow), '0);

        // reset during WAIT_RD abandons the read; late data is ignored
        c1_enable = 1'b1; c1_read = 1'b1; c1_addr = 27'h0000700;
        tick();
        c1_enable = 1'b0;
        tick();
        check("wr grant", DW'(mem_enable), DW'(1'b1));
        tick();
        check("wr accepted", DW'(mem_enable), '0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_all_zero("after reset");
        mem_available = 1'b1; mem_data = rep8(8'h66);
        tick();
        mem_available = 1'b0;
        check("late c1_available", DW'(c1_available), '0);
        check("late c0_available", DW'(c0_available), '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all_zero("post reset idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr2_arbiter.md
# ddr2_arbiter

Shares the single DDR2 memory-controller port between two direct-mapped caches: port 0 is the instruction cache and port 1 is the data cache. Each cache issues one-cycle command pulses, and the block queues them per port. It grants the memory port round-robin and returns each read line only to the cache that requested it. Write-back followed by refill from the same cache reaches memory in issue order.

## Interface
- ADDR_W, 27, byte address width (same as cache `ddr2_addr`)
- DATA_W, 128, line width
- QDEPTH, 2, per-port command FIFO depth (power of two, ≥2)

- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- cN_enable  in  1  (N=0,1) one-cycle command pulse from cache N
- cN_read  in  1  1 = line read, 0 = line write
- cN_addr  in  ADDR_W  command address
- cN_wdata  in  DATA_W  write line (ignored for reads)
- cN_available  out  1  one-cycle pulse: cN_rdata valid
- cN_rdata  out  DATA_W  returned read line, held until next return to port N
- cN_overflow  out  1  sticky: command dropped on full FIFO
- mem_enable  out  1  command valid to memory controller
- mem_read  out  1  command type
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  write line
- mem_ready  in  1  command accepted when mem_enable & mem_ready at an edge
- mem_available  in  1  one-cycle pulse: mem_data holds read line
- mem_data  in  DATA_W  read line

## Operation
- Each port has a FIFO of {read, addr, wdata}, QDEPTH entries.
- Push occurs on cN_enable at an edge. Pop occurs when the head is accepted by memory.
- Push and pop in the same cycle are legal at any occupancy, including full.
- A push on a full FIFO with no pop is dropped and sets cN_overflow. cN_overflow clears only on reset.
- Arbiter FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE, transitions:
  - Both FIFOs empty: stay in IDLE.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the port ≠ last_grant.
  - On any grant: record owner, update last_grant, go to ISSUE.
- ISSUE:
  - mem_enable=1; mem_read/addr/wdata are driven from the owner FIFO head and held stable until acceptance.
  - On mem_ready, pop the head. A write goes to IDLE; a read goes to WAIT_RD.
- WAIT_RD:
  - mem_enable=0.
  - On mem_available, register mem_data into cOwner_rdata, pulse cOwner_available next cycle, and go to IDLE.
- At most one memory command outstanding. A write is complete at acceptance.
- Per-port order is strictly preserved. Cross-port order is arbitration order only; no coherence between ports.
- mem_available outside WAIT_RD is ignored. The other port's rdata/available are never disturbed.

## Timing
- Reset (rstn=0 at an edge):
  - FIFOs emptied; FSM→IDLE; last_grant=1, so port 0 wins the first tie.
  - Every output is 0: mem_enable, mem_read, mem_addr, mem_wdata, cN_available, cN_rdata, cN_overflow.
  - Reset mid-ISSUE or mid-WAIT_RD abandons the command. A late mem_available is then ignored (FSM in IDLE).
- Latency, empty block, mem_ready tied 1:
  - cN_enable sampled at edge T.
  - Grant at edge T+1.
  - mem_enable high during cycle after T+1, and accepted at edge T+2.
  - mem_available sampled at edge R gives cN_available high for exactly the cycle after R.
- Minimum issue spacing: one command per 2 cycles (IDLE→ISSUE→IDLE).
- A read blocks all issue until its data returns.
- A write-back pulse followed next cycle by a refill pulse from the same cache occupies two FIFO entries. Write is issued first; read is issued after the write is accepted.
- mem_enable falls in the cycle after acceptance (registered FSM).

## Test plan
- Single read, port 0, addr=0x0000120, mem_ready=1, mem_available 5 cycles after accept with data=0xA5..A5: mem_enable at T+2, accept once, c0_rdata=0xA5..A5 with one-cycle c0_available; c1_available stays 0.
- Port 1 write-back addr=0x0004010 then next-cycle read addr=0x0008010: memory sees write (mem_read=0, wdata intact) then read; only c1_available pulses on return.
- Both ports pulse read in the same cycle after reset: port 0 issued first, port 1 second. Repeat with both pending: grant alternates 1,0.
- mem_ready held 0 for 10 cycles in ISSUE: mem_addr/wdata/read stable throughout, no pop; accepted on the first ready edge.
- Three pulses to port 0 with mem_ready=0 (QDEPTH=2): third dropped, c0_overflow=1 and stays 1; first two issue in order once ready.
- rstn=0 during WAIT_RD, then mem_available pulses after reset release: no cN_available, FIFOs empty, all outputs 0.
